// File: rtl/frame_checker_pkg.sv
// Shared types and constants for the RX frame checker: header layout, per-port
// statistics and the test-frame signature.
package frame_checker_pkg;

  typedef logic [31:0] u32_t;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int FRAME_HDR_BYTES = 34;

  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  TEST_FRAME_TOS   = 8'h28;
  localparam logic [7:0]  TEST_FRAME_PROTO = 8'hFD;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] len;
    logic [15:0] id;
    logic [15:0] frag;
    logic [7:0]  ttl;
    logic [7:0]  proto;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } ip_header_t;

  // Wire order: frame byte 0 lands in the most significant byte.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    ip_header_t  ip_header;
  } frame_header_t;

  typedef struct packed {
    u32_t recv_frames;
    u32_t recv_bytes;
    u32_t err_frames;
    u32_t err_bytes;
  } port_result_t;

  typedef enum logic {HEAD, BODY} rx_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/frame_stats_acc.sv
// Per-port statistics accumulator. Commits one registered verdict per cycle;
// clear takes priority over a verdict landing in the same cycle.
module frame_stats_acc
  import frame_checker_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         good,
  input  logic         bad,
  input  logic [13:0]  bytes,
  output port_result_t result
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      result <= '0;
    end else begin
      if (good) begin
        result.recv_frames <= result.recv_frames + 32'd1;
        result.recv_bytes  <= result.recv_bytes + 32'(bytes);
      end
      if (bad) begin
        result.err_frames <= result.err_frames + 32'd1;
        result.err_bytes  <= result.err_bytes + 32'(bytes);
      end
    end
  end

endmodule

// File: rtl/ip_header_checksum.sv
// IPv4 header checksum generator: ones-complement sum of the ten header words
// with the checksum field taken as zero. Purely combinational.
module ip_header_checksum
  import frame_checker_pkg::*;
(
  input  ip_header_t  ip_header,
  output logic [15:0] checksum
);

  ip_header_t  hdr_z;
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    hdr_z          = ip_header;
    hdr_z.checksum = '0;
    sum            = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(hdr_z[16*i +: 16]);
    // Two folds are enough: the first leaves at most one carry.
    fold1    = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2    = fold1[15:0] + 16'(fold1[16]);
    checksum = ~fold2;
  end

endmodule

// File: rtl/frame_checker.sv
// RX-side frame checker: captures the Ethernet/IPv4 header from a 64-bit
// AXI-Stream, classifies each frame on tlast and accumulates port statistics.
module frame_checker
  import frame_checker_pkg::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  s_tdata,
  input  logic [7:0]   s_tkeep,
  input  logic         s_tvalid,
  input  logic         s_tlast,
  input  logic         s_tuser,
  output logic         s_tready,
  input  logic         enable,
  input  logic         clear,
  output port_result_t result
);

  localparam int HDR_BEATS = 5;

  rx_state_e                         state_q, state_d;
  logic                              hdr_cap;
  logic [2:0]                        beat_idx;
  logic [FRAME_HDR_BYTES-1:0][7:0]   hdr_q, hdr_d;
  frame_header_t                     hdr;
  logic [13:0]                       cnt_q, cnt_d;
  logic [14:0]                       cnt_sum;
  logic                              en_q, frame_en;
  logic [15:0]                       csum;
  logic                              is_runt, is_test, good_d, bad_d;
  logic                              v_good, v_bad;
  logic [13:0]                       v_cnt;
  logic                              unused_mac;

  assign s_tready = rst_n;

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= HEAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s_tvalid) begin
      if (s_tlast)
        state_d = HEAD;
      else if (state_q == HEAD && beat_idx == 3'(HDR_BEATS-1))
        state_d = BODY;
    end
  end

  always_comb hdr_cap = (state_q == HEAD);

  // The tlast beat may still carry header bytes, so classification looks at
  // the merged next-header value rather than the register.
  always_comb begin
    hdr_d = hdr_q;
    if (s_tvalid && hdr_cap)
      for (int k = 0; k < FRAME_HDR_BYTES; k++)
        if (beat_idx == 3'(k/8) && s_tkeep[k%8])
          hdr_d[FRAME_HDR_BYTES-1-k] = s_tdata[8*(k%8) +: 8];
  end

  assign hdr        = frame_header_t'(hdr_d);
  assign unused_mac = ^{hdr.dst_mac, hdr.src_mac};

  always_comb begin
    cnt_sum  = {1'b0, cnt_q} + 15'(popcount8(s_tkeep));
    cnt_d    = cnt_sum[14] ? 14'h3FFF : cnt_sum[13:0];
    frame_en = (beat_idx == 3'd0) ? enable : en_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx <= '0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      hdr_q    <= '0;
    end else if (s_tvalid) begin
      if (s_tlast)                        beat_idx <= '0;
      else if (beat_idx != 3'(HDR_BEATS)) beat_idx <= beat_idx + 3'd1;
      en_q  <= frame_en;
      cnt_q <= s_tlast ? '0 : cnt_d;
      hdr_q <= hdr_d;
    end
  end

  ip_header_checksum u_csum (
    .ip_header (hdr.ip_header),
    .checksum  (csum)
  );

  always_comb begin
    is_runt = cnt_d < 14'(FRAME_HDR_BYTES);
    is_test = hdr.ethertype == ETHERTYPE_IPV4 &&
              hdr.ip_header.version == 4'd4 && hdr.ip_header.ihl == 4'd5 &&
              hdr.ip_header.tos == TEST_FRAME_TOS &&
              hdr.ip_header.proto == TEST_FRAME_PROTO;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    if (s_tvalid && s_tlast && frame_en) begin
      if (is_runt) begin
        bad_d = s_tuser;
      end else if (is_test) begin
        good_d = !s_tuser && csum == hdr.ip_header.checksum &&
                 17'(cnt_d) == 17'(hdr.ip_header.len) + 17'(ETH_HDR_BYTES);
        bad_d  = !good_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_good <= 1'b0;
      v_bad  <= 1'b0;
      v_cnt  <= '0;
    end else begin
      v_good <= good_d;
      v_bad  <= bad_d;
      v_cnt  <= cnt_d;
    end
  end

  frame_stats_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .good   (v_good),
    .bad    (v_bad),
    .bytes  (v_cnt),
    .result (result)
  );

  always_ff @(posedge clk)
    if (rst_n && s_tvalid)
      assert (s_tkeep != '0) else $error("frame_checker[%0d]: beat with empty tkeep", PORT_ID);

endmodule

// File: doc/frame_checker.md
# frame_checker

Receive-side checker for the speed tester. It sits downstream of the MAC RX FIFO for one port and consumes the 64-bit AXI-Stream of received frames. It parses the Ethernet/IPv4 header of each frame, validates it with the shared `ip_header_checksum` module, and accumulates that port's `port_result_t` (recv/err frames and bytes) for the register file.

## Interface
- `PORT_ID`, 0: port index; debug/assertion labels only.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_tdata`  in  64  frame bytes, byte k of beat at `[8k+7:8k]`; frame byte 0 is `s_tdata[7:0]` of beat 0.
- `s_tkeep`  in  8  byte valid mask, contiguous from bit 0.
- `s_tvalid`  in  1  beat valid.
- `s_tlast`  in  1  last beat of frame.
- `s_tuser`  in  1  MAC error flag; sampled on the `tlast` beat only.
- `s_tready`  out  1  constant 1 outside reset. The checker never stalls.
- `enable`  in  1  test window active; sampled on beat 0 of each frame.
- `clear`  in  1  one-cycle pulse; zeroes `result`.
- `result`  out  `port_result_t`  running statistics.

## Operation
- Beat counter `beat_idx` (3 bits) counts accepted beats in the frame and saturates at 5. It returns to 0 the cycle after a `tlast` beat is accepted.
- Beats 0–4 are stored into a `frame_header_t` register, bytes 0–33. Bytes 34–39 of beat 4 are ignored.
- Frame byte count is the sum of popcount(`s_tkeep`) over all beats. It is 14 bits and saturates at 16383.
- Classification is evaluated on the `tlast` beat. A frame is test-class when all of the following hold:
  - frame bytes 12..13 are 0x08, 0x00;
  - `version`=4 and `ihl`=5;
  - `tos`=`TEST_FRAME_TOS`;
  - `proto`=`TEST_FRAME_PROTO`.
- A test-class frame is good when all of the following hold; otherwise it is bad:
  - `s_tuser`=0;
  - the computed checksum equals the received `checksum` field;
  - byte count = `len` + 14.
- A runt frame (fewer than 34 bytes) is bad when `s_tuser`=1; otherwise it is ignored.
- Any other frame that is not test-class is ignored.
- Frames whose beat 0 arrived with `enable`=0 are ignored entirely, even if `enable` rises mid-frame.
- Counter updates:
  - good frame: `recv_frames`+=1 and `recv_bytes`+=count;
  - bad frame: `err_frames`+=1 and `err_bytes`+=count.
  - All four are 32-bit and wrap modulo 2^32.
- State machine:
  - HEAD (beat_idx<5) → BODY after beat 4 without `tlast`.
  - Any `tlast` beat → HEAD.
  - Reset → HEAD.

## Timing
- Reset values: `result`=0, `s_tready`=0 while `rst_n`=0, header register 0, beat_idx 0, state HEAD.
- Pipeline:
  - cycle N: `tlast` beat accepted.
  - N+1: registered verdict {good, bad, count}.
  - N+2: `result` updated and visible.
- Back-to-back frames (a `tlast` beat followed immediately by the next beat 0) are fully supported. One frame per cycle is possible when each frame is a single beat.
- `clear` at cycle C gives `result`=0 at C+1. If a verdict commits in the same cycle as `clear`, `clear` wins and that frame is dropped.
- Reset mid-frame discards the partial frame. The next accepted beat is treated as beat 0.
- `s_tvalid`=0 gaps inside a frame are allowed. The counter advances only on `s_tvalid`.

## Structure
- Shared package holds:
  - `frame_header_t`, `port_result_t`, `u32_t`;
  - `TEST_FRAME_TOS`, `TEST_FRAME_PROTO`;
  - new `ETH_HDR_BYTES`=14 and `FRAME_HDR_BYTES`=34.
- Instantiate one `ip_header_checksum` on the captured `ip_header`. Its output is combinational and is used only at verdict time.
- Natural sub-module: `frame_stats_acc`. It holds the four counters, the clear priority, and the N+1→N+2 commit.

## Test plan
- Good 64-byte test frame (`len`=50, valid checksum, `enable`=1) → `recv_frames`=1, `recv_bytes`=64, err=0 at N+2.
- Same frame with `s_tuser`=1 → `err_frames`=1, `err_bytes`=64, recv unchanged.
- Corrupt checksum by 1, then a 1514-byte frame with `len`=1400 → `err_frames`=2; `err_bytes`=64+1514.
- Ethertype 0x86DD frame, plus a 20-byte runt with `tuser`=0 → all counters unchanged.
- 1000 back-to-back 64-byte good frames with `tvalid` gaps inserted → `recv_frames`=1000, `recv_bytes`=64000.
- `clear` coincident with a verdict commit → `result`=0. `enable` rising after beat 0 → that frame is not counted.
